ecc_channel_link: RTL and testbench

- Parametrised successor to the single-word audio transmission `System`, for multi-channel sample frames.
- Accepts one frame of N_CH audio samples over a valid/ready handshake and serialises the channels through one SECDED encoder.
- Each codeword passes a pseudo-random bit-flip noise injector and a SECDED decoder; the corrected frame is returned over valid/ready with per-channel error flags and saturating error counters.
- Sits between the audio source and sink as the channel model plus ECC under test.

---
 rtl/ecc_link_pkg.sv | 39 +++
 rtl/secded_codec.sv | 91 +++++++++
 rtl/ecc_channel_link.sv | 184 ++++++++++++++++++
 tb/tb_ecc_channel_link.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_link_pkg.sv
// ecc_link_pkg
// Shared definitions for the ECC channel link:
//   calc_p / calc_cw : SECDED check-bit count and extended codeword width
//   LFSR_MASK        : Galois feedback mask for the 32-bit noise LFSR
//   DEFAULT_SEED     : reset value of the noise LFSR
//   noise_mode_e     : noise injector operating modes
//   link_state_e     : frame-serialiser FSM states
package ecc_link_pkg;

    localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1234;

    typedef enum logic [1:0] {
        NOISE_OFF,
        NOISE_SINGLE,
        NOISE_DOUBLE,
        NOISE_RANDOM
    } noise_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        SERIAL,
        OUT
    } link_state_e;

    // Smallest r such that 2^r >= data_w + r + 1.
    function automatic int calc_p(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < (data_w + r + 1)) r++;
        return r;
    endfunction

    // Hamming positions plus one overall-parity bit in the MSB.
    function automatic int calc_cw(input int data_w);
        return data_w + calc_p(data_w) + 1;
    endfunction

endpackage

// File: rtl/secded_codec.sv
// secded_codec
// Combinational extended-Hamming (SECDED) encoder and decoder.
// Codeword bit b holds Hamming position b+1 for b < CW-1; check bits sit at
// power-of-two positions, data bits fill the remaining positions in ascending
// order, and bit CW-1 is the overall parity of the whole word.
// Ports:
//   enc_data   : data word to encode
//   enc_code   : encoded codeword
//   dec_code   : (possibly corrupted) codeword to decode
//   dec_data   : decoded data (corrected on single error, raw on double)
//   dec_corr   : single-bit error detected and corrected
//   dec_uncorr : double-bit error detected, data not corrected
module secded_codec
    import ecc_link_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic [DATA_W-1:0]          enc_data,
    output logic [calc_cw(DATA_W)-1:0] enc_code,
    input  logic [calc_cw(DATA_W)-1:0] dec_code,
    output logic [DATA_W-1:0]          dec_data,
    output logic                       dec_corr,
    output logic                       dec_uncorr
);

    localparam int P  = calc_p(DATA_W);
    localparam int CW = calc_cw(DATA_W);
    localparam int HW = DATA_W + P;

    logic [CW-1:0] code_w;
    logic [CW-1:0] fixed_w;
    logic [P-1:0]  syn;
    logic          parity_bad;
    logic          par;
    int            d_enc;
    int            d_dec;

    always_comb begin
        code_w = '0;
        par    = 1'b0;
        d_enc  = 0;
        for (int h = 1; h <= HW; h++) begin
            if ((h & (h - 1)) != 0) begin
                code_w[h-1] = enc_data[d_enc];
                d_enc++;
            end
        end
        // Check bit r covers every position with bit r set; its own slot is
        // still zero while the parity is accumulated.
        for (int r = 0; r < P; r++) begin
            par = 1'b0;
            for (int h = 1; h <= HW; h++) begin
                if (((h >> r) & 1) != 0) par ^= code_w[h-1];
            end
            code_w[(1 << r) - 1] = par;
        end
        code_w[CW-1] = ^code_w[CW-2:0];
    end

    assign enc_code = code_w;

    always_comb begin
        syn = '0;
        for (int h = 1; h <= HW; h++) begin
            if (dec_code[h-1]) syn ^= P'(h);
        end
    end

    assign parity_bad = ^dec_code;

    always_comb begin
        fixed_w  = dec_code;
        dec_data = '0;
        d_dec    = 0;
        // Syndrome 0 with bad parity means the overall parity bit itself
        // flipped; nothing in the Hamming field needs fixing.
        for (int h = 1; h <= HW; h++) begin
            if (parity_bad && (syn == P'(h))) fixed_w[h-1] = ~fixed_w[h-1];
        end
        for (int h = 1; h <= HW; h++) begin
            if ((h & (h - 1)) != 0) begin
                dec_data[d_dec] = fixed_w[h-1];
                d_dec++;
            end
        end
    end

    assign dec_corr   = parity_bad;
    assign dec_uncorr = !parity_bad && (syn != '0);

endmodule

// File: rtl/ecc_channel_link.sv
// ecc_channel_link
// Accepts a frame of N_CH samples, pushes each channel in turn through a
// SECDED encoder, an LFSR-driven bit-flip injector and a SECDED decoder, and
// presents the decoded frame with per-channel flags and saturating counters.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input frame handshake, in_data frame payload
//   noise_mode           : injector mode, captured when a frame is accepted
//   out_valid/out_ready  : output frame handshake
//   out_data             : decoded frame (same channel layout as in_data)
//   out_corr/out_uncorr  : per-channel corrected / uncorrectable flags
//   corr_count/uncorr_count : saturating error word counters
//   clear_counts         : synchronous clear of both counters
module ecc_channel_link
    import ecc_link_pkg::*;
#(
    parameter int          DATA_W    = 24,
    parameter int          N_CH      = 2,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [1:0]             noise_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_corr,
    output logic [N_CH-1:0]        out_uncorr,
    output logic [CNT_W-1:0]       corr_count,
    output logic [CNT_W-1:0]       uncorr_count,
    input  logic                   clear_counts
);

    localparam int CW    = calc_cw(DATA_W);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    link_state_e            state;
    logic [IDX_W-1:0]       idx;
    logic [31:0]            lfsr;
    logic [N_CH*DATA_W-1:0] frame_p0;
    noise_mode_e            mode_p0;
    logic [N_CH*DATA_W-1:0] data_p1;
    logic [N_CH-1:0]        corr_p1;
    logic [N_CH-1:0]        uncorr_p1;
    logic [CNT_W-1:0]       corr_cnt;
    logic [CNT_W-1:0]       uncorr_cnt;

    logic [DATA_W-1:0] chan_data;
    logic [DATA_W-1:0] dec_data;
    logic [CW-1:0]     code;
    logic [CW-1:0]     flip_mask;
    logic              dec_corr;
    logic              dec_uncorr;
    logic [15:0]       p1;
    logic [15:0]       p2_raw;
    logic [15:0]       p2;
    logic              flip1;
    logic              flip2;
    logic              serial_act;
    logic              accept;

    assign accept     = (state == IDLE) && in_valid;
    assign serial_act = (state == SERIAL);
    assign chan_data  = frame_p0[idx*DATA_W +: DATA_W];

    // ---- stage p0 -> p1 boundary: encode, inject noise, decode ----
    // Scaling a 16-bit random value by CW keeps the flip position in range
    // without a modulo.
    assign p1     = 16'((32'(lfsr[15:0])  * 32'(CW)) >> 16);
    assign p2_raw = 16'((32'(lfsr[31:16]) * 32'(CW)) >> 16);
    assign p2     = (p2_raw != p1) ? p2_raw :
                    (p1 == 16'(CW - 1)) ? 16'd0 : p1 + 16'd1;

    always_comb begin
        flip1 = 1'b0;
        flip2 = 1'b0;
        case (mode_p0)
            NOISE_SINGLE: flip1 = 1'b1;
            NOISE_DOUBLE: begin
                flip1 = 1'b1;
                flip2 = 1'b1;
            end
            NOISE_RANDOM: begin
                flip1 = (lfsr[17:16] != 2'b00);
                flip2 = (lfsr[17:16] == 2'b11);
            end
            default: ;
        endcase
    end

    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < CW; i++) begin
            flip_mask[i] = (flip1 && (p1 == 16'(i))) || (flip2 && (p2 == 16'(i)));
        end
    end

    secded_codec #(
        .DATA_W(DATA_W)
    ) u_codec (
        .enc_data   (chan_data),
        .enc_code   (code),
        .dec_code   (code ^ flip_mask),
        .dec_data   (dec_data),
        .dec_corr   (dec_corr),
        .dec_uncorr (dec_uncorr)
    );

    // ---- stage p0: frame and mode capture at accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_p0 <= in_data;
            mode_p0  <= noise_mode_e'(noise_mode);
        end
    end

    // ---- stage p1: per-channel result slots and control ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            lfsr      <= LFSR_SEED;
            data_p1   <= '0;
            corr_p1   <= '0;
            uncorr_p1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx   <= '0;
                        state <= SERIAL;
                    end
                end
                SERIAL: begin
                    data_p1[idx*DATA_W +: DATA_W] <= dec_data;
                    corr_p1[idx]                  <= dec_corr;
                    uncorr_p1[idx]                <= dec_uncorr;
                    lfsr                          <= lfsr_next(lfsr);
                    if (idx == LAST_IDX) state <= OUT;
                    else                 idx   <= idx + IDX_W'(1);
                end
                OUT: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clear_counts) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (serial_act) begin
            corr_cnt   <= sat_inc(corr_cnt, dec_corr);
            uncorr_cnt <= sat_inc(uncorr_cnt, dec_uncorr);
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == OUT);
    assign out_data     = data_p1;
    assign out_corr     = corr_p1;
    assign out_uncorr   = uncorr_p1;
    assign corr_count   = corr_cnt;
    assign uncorr_count = uncorr_cnt;

endmodule

// File: tb/tb_ecc_channel_link.sv
`timescale 1ns/1ps
module tb_ecc_channel_link;

    localparam int          DW   = 24;
    localparam int          CW   = 30;
    localparam logic [31:0] SEED = 32'hACE1_1234;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dmap[CW];

    // Instance A: 2 channels, 16-bit counters
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
    logic [47:0] a_in_data, a_out_data;
    logic [1:0]  a_mode, a_corr, a_uncorr;
    logic [15:0] a_cc, a_uc;

    // Instance B: 4 channels, 4-bit counters
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
    logic [95:0] b_in_data, b_out_data;
    logic [1:0]  b_mode;
    logic [3:0]  b_corr, b_uncorr, b_cc, b_uc;

    logic [31:0] ma_lfsr, mb_lfsr;
    int          ma_cc, ma_uc, mb_cc, mb_uc;

    ecc_channel_link #(.DATA_W(24), .N_CH(2), .CNT_W(16), .LFSR_SEED(SEED)) dut_a (
        .clk(clk), .reset(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .noise_mode(a_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_corr(a_corr), .out_uncorr(a_uncorr),
        .corr_count(a_cc), .uncorr_count(a_uc), .clear_counts(a_clr)
    );

    ecc_channel_link #(.DATA_W(24), .N_CH(4), .CNT_W(4), .LFSR_SEED(SEED)) dut_b (
        .clk(clk), .reset(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .noise_mode(b_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_corr(b_corr), .out_uncorr(b_uncorr),
        .corr_count(b_cc), .uncorr_count(b_uc), .clear_counts(b_clr)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference for one channel: count the flips the rules call for; one flip
    // is always repaired, two flips leave the data with whichever data bits
    // were hit still inverted.
    task automatic model_chan(input logic [23:0] din, input logic [1:0] mode,
                              input logic [31:0] lf, output logic [23:0] dout,
                              output logic c, output logic u);
        int p1, p2, nflip;
        p1 = (int'(lf[15:0]) * CW) / 65536;
        p2 = (int'(lf[31:16]) * CW) / 65536;
        if (p2 == p1) p2 = (p1 + 1) % CW;
        case (mode)
            2'd0: nflip = 0;
            2'd1: nflip = 1;
            2'd2: nflip = 2;
            default: nflip = (lf[17:16] == 2'b00) ? 0 : (lf[17:16] == 2'b11) ? 2 : 1;
        endcase
        dout = din;
        c = (nflip == 1);
        u = (nflip == 2);
        if (nflip == 2) begin
            if (dmap[p1] >= 0) dout[dmap[p1]] = ~dout[dmap[p1]];
            if (dmap[p2] >= 0) dout[dmap[p2]] = ~dout[dmap[p2]];
        end
    endtask

    task automatic run_a(input logic [47:0] d, input logic [1:0] m, input int hold);
        logic [47:0] exp_d;
        logic [1:0]  exp_c, exp_u;
        logic [23:0] cd;
        logic        c, u;
        int          w, lat;
        for (int k = 0; k < 2; k++) begin
            model_chan(d[k*24 +: 24], m, ma_lfsr, cd, c, u);
            exp_d[k*24 +: 24] = cd;
            exp_c[k] = c;
            exp_u[k] = u;
            if (c && ma_cc < 65535) ma_cc++;
            if (u && ma_uc < 65535) ma_uc++;
            ma_lfsr = m_lfsr_step(ma_lfsr);
        end
        w = 0;
        while (!a_in_ready && w < 20) begin @(posedge clk); #1; w++; end
        chk("a_in_ready_idle", 128'(a_in_ready), 128'(1));
        a_in_data = d; a_mode = m; a_in_valid = 1'b1; a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_mode = ~m;
        a_in_data = 48'({$urandom(), $urandom()});
        lat = 0;
        while (!a_out_valid && lat < 20) begin
            chk("a_in_ready_busy", 128'(a_in_ready), 128'(0));
            @(posedge clk); #1; lat++;
        end
        chk("a_latency", 128'(lat), 128'(2));
        chk("a_out_data", 128'(a_out_data), 128'(exp_d));
        chk("a_out_corr", 128'(a_corr), 128'(exp_c));
        chk("a_out_uncorr", 128'(a_uncorr), 128'(exp_u));
        chk("a_corr_count", 128'(a_cc), 128'(ma_cc));
        chk("a_uncorr_count", 128'(a_uc), 128'(ma_uc));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("a_hold_valid", 128'(a_out_valid), 128'(1));
            chk("a_hold_data", 128'({a_out_data, a_corr, a_uncorr}), 128'({exp_d, exp_c, exp_u}));
            chk("a_hold_in_ready", 128'(a_in_ready), 128'(0));
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk("a_release_valid", 128'(a_out_valid), 128'(0));
    endtask

    task automatic run_b(input logic [95:0] d, input logic [1:0] m, input bit clr_first);
        logic [95:0] exp_d;
        logic [3:0]  exp_c, exp_u;
        logic [23:0] cd;
        logic        c, u;
        int          w, lat;
        for (int k = 0; k < 4; k++) begin
            model_chan(d[k*24 +: 24], m, mb_lfsr, cd, c, u);
            exp_d[k*24 +: 24] = cd;
            exp_c[k] = c;
            exp_u[k] = u;
            if (k == 0 && clr_first) begin
                mb_cc = 0;
                mb_uc = 0;
            end else begin
                if (c && mb_cc < 15) mb_cc++;
                if (u && mb_uc < 15) mb_uc++;
            end
            mb_lfsr = m_lfsr_step(mb_lfsr);
        end
        w = 0;
        while (!b_in_ready && w < 20) begin @(posedge clk); #1; w++; end
        chk("b_in_ready_idle", 128'(b_in_ready), 128'(1));
        b_in_data = d; b_mode = m; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_mode = ~m;
        lat = 0;
        if (clr_first) begin
            b_clr = 1'b1;
            @(posedge clk); #1;
            b_clr = 1'b0;
            lat = 1;
            chk("b_clear_wins", 128'(b_cc), 128'(0));
        end
        while (!b_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("b_latency", 128'(lat), 128'(4));
        chk("b_out_data", 128'(b_out_data), 128'(exp_d));
        chk("b_out_flags", 128'({b_corr, b_uncorr}), 128'({exp_c, exp_u}));
        chk("b_counts", 128'({b_cc, b_uc}), 128'({4'(mb_cc), 4'(mb_uc)}));
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("b_release_valid", 128'(b_out_valid), 128'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        k = 0;
        for (int b = 0; b < CW; b++) begin
            if (b == CW - 1 || (((b + 1) & b) == 0)) dmap[b] = -1;
            else begin dmap[b] = k; k++; end
        end
        rst_n = 1'b0;
        a_in_valid = 0; a_out_ready = 0; a_clr = 0; a_in_data = '0; a_mode = 0;
        b_in_valid = 0; b_out_ready = 0; b_clr = 0; b_in_data = '0; b_mode = 0;
        ma_lfsr = SEED; mb_lfsr = SEED; ma_cc = 0; ma_uc = 0; mb_cc = 0; mb_uc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_in_ready", 128'(a_in_ready), 128'(1));
        chk("rst_a_out", 128'({a_out_valid, a_out_data, a_corr, a_uncorr}), 128'(0));
        chk("rst_a_counts", 128'({a_cc, a_uc}), 128'(0));
        chk("rst_b_out", 128'({b_out_valid, b_out_data, b_corr, b_uncorr, b_cc, b_uc}), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean channel
        run_a({24'hABCDEF, 24'h000001}, 2'd0, 0);
        chk("a_mode0_data", 128'(a_out_data), 128'({24'hABCDEF, 24'h000001}));

        // Single flips: always repaired
        for (int i = 0; i < 1000; i++) run_a(48'({$urandom(), $urandom()}), 2'd1, 0);
        chk("a_mode1_corr_total", 128'(a_cc), 128'(2000));
        chk("a_mode1_uncorr_total", 128'(a_uc), 128'(0));

        // Double flips: always flagged, never corrected
        for (int i = 0; i < 10; i++) run_a(48'({$urandom(), $urandom()}), 2'd2, 0);
        chk("a_mode2_uncorr_total", 128'(a_uc), 128'(20));
        chk("a_mode2_flags", 128'({a_corr, a_uncorr}), 128'(4'b0011));

        // Backpressure
        run_a(48'h123456_FEDCBA, 2'd1, 5);

        // Random noise mix
        for (int i = 0; i < 40; i++) run_a(48'({$urandom(), $urandom()}), 2'd3, i % 3);

        // Counter clear while idle
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        ma_cc = 0; ma_uc = 0;
        chk("a_clear", 128'({a_cc, a_uc}), 128'(0));

        // Saturating 4-bit counters on the wide instance
        for (int i = 0; i < 10; i++) run_b({$urandom(), $urandom(), $urandom()}, 2'd1, 1'b0);
        chk("b_sat", 128'(b_cc), 128'(15));
        run_b({$urandom(), $urandom(), $urandom()}, 2'd1, 1'b1);
        chk("b_after_clear", 128'(b_cc), 128'(3));

        // Reset two channels into a frame
        b_in_data = {$urandom(), $urandom(), $urandom()};
        b_mode = 2'd1;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("b_mid_valid", 128'(b_out_valid), 128'(0));
        chk("b_mid_count", 128'(b_cc), 128'(5));
        rst_n = 1'b0;
        #1;
        chk("b_rst_in_ready", 128'(b_in_ready), 128'(1));
        chk("b_rst_out", 128'({b_out_valid, b_out_data, b_corr, b_uncorr}), 128'(0));
        chk("b_rst_counts", 128'({b_cc, b_uc, a_cc, a_uc}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ma_lfsr = SEED; mb_lfsr = SEED; ma_cc = 0; ma_uc = 0; mb_cc = 0; mb_uc = 0;
        @(posedge clk); #1;
        run_b({$urandom(), $urandom(), $urandom()}, 2'd3, 1'b0);
        run_b({$urandom(), $urandom(), $urandom()}, 2'd2, 1'b0);
        run_a(48'({$urandom(), $urandom()}), 2'd3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
